// File: rtl/branch_res_seq.sv
// Multi-cycle branch resolution engine. One CHUNK-wide adder is shared by
// the condition compare (rs1 - rs2) and the target add (pc + sext(imm_sb)),
// each walking the word LSB chunk first.
//
//   state | meaning
//   ------+-----------------------------------------------
//   IDLE  | waiting for a request, req_ready high
//   CMP   | N cycles of rs1 + ~rs2 + carry, builds eq/lt flags
//   ADDR  | N cycles of pc + off + carry into the address accumulator
//   DONE  | result presented, waiting for resp_ready
//
// WORD_SIZE must be a multiple of CHUNK.
module branch_res_seq #(
  parameter int WORD_SIZE = 32,
  parameter int CHUNK     = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [2:0]           branch_type,
  input  logic [WORD_SIZE-1:0] rs1_data,
  input  logic [WORD_SIZE-1:0] rs2_data,
  input  logic [WORD_SIZE-1:0] pc,
  input  logic [12:0]          imm_sb,
  input  logic                 flush,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 branch_taken,
  output logic [WORD_SIZE-1:0] branch_addr,
  output logic                 busy
);

  localparam int N  = WORD_SIZE / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CMP  = 2'd1;
  localparam logic [1:0] ADDR = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]           state;
  logic [CW-1:0]        cnt;
  logic                 carry;
  logic [2:0]           type_r;
  logic [WORD_SIZE-1:0] op_a;
  logic [WORD_SIZE-1:0] op_b;
  logic [WORD_SIZE-1:0] pc_r;
  logic [WORD_SIZE-1:0] off_r;
  logic [WORD_SIZE-1:0] addr_acc;
  logic                 eq_acc;
  logic                 cout;
  logic                 dsign;
  logic                 s1;
  logic                 s2;

  logic [CHUNK-1:0]     a_sel;
  logic [CHUNK-1:0]     b_sel;
  logic [CHUNK:0]       sum;
  logic [WORD_SIZE-1:0] addr_next;
  logic                 lt;
  logic                 ltu;
  logic                 taken_next;
  logic                 accept;
  logic                 last;

  assign req_ready = (state == IDLE) & ~flush & ~RST;
  assign busy      = (state != IDLE);
  assign accept    = req_valid & req_ready;
  assign last      = (cnt == LAST);

  // Shared adder: operand mux picks compare or target-add operands.
  always_comb begin
    a_sel = pc_r[CHUNK-1:0];
    b_sel = off_r[CHUNK-1:0];
    if (state == CMP) begin
      a_sel = op_a[CHUNK-1:0];
      b_sel = ~op_b[CHUNK-1:0];
    end
    sum = {1'b0, a_sel} + {1'b0, b_sel} + {{CHUNK{1'b0}}, carry};
  end

  // New chunk enters at the top of the accumulator so it is complete after N steps.
  always_comb begin
    addr_next = (addr_acc >> CHUNK) |
                (WORD_SIZE'(sum[CHUNK-1:0]) << (WORD_SIZE - CHUNK));
  end

  // Branch condition from the flags latched at the end of CMP.
  always_comb begin
    lt  = (s1 != s2) ? s1 : dsign;
    ltu = ~cout;
    case (type_r)
      3'b000:  taken_next = eq_acc;
      3'b001:  taken_next = ~eq_acc;
      3'b100:  taken_next = lt;
      3'b101:  taken_next = ~lt;
      3'b110:  taken_next = ltu;
      3'b111:  taken_next = ~ltu;
      default: taken_next = 1'b0;
    endcase
  end

  // Sequencer: state, chunk counter, inter-chunk carry and response valid.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= '0;
      carry      <= 1'b0;
      resp_valid <= 1'b0;
    end else if (flush) begin
      state      <= IDLE;
      cnt        <= '0;
      carry      <= 1'b0;
      resp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= CMP;
            cnt   <= '0;
            carry <= 1'b1;
          end
        end
        CMP: begin
          if (last) begin
            state <= ADDR;
            cnt   <= '0;
            carry <= 1'b0;
          end else begin
            cnt   <= cnt + 1'b1;
            carry <= sum[CHUNK];
          end
        end
        ADDR: begin
          if (last) begin
            state      <= DONE;
            cnt        <= '0;
            carry      <= 1'b0;
            resp_valid <= 1'b1;
          end else begin
            cnt   <= cnt + 1'b1;
            carry <= sum[CHUNK];
          end
        end
        default: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
          end
        end
      endcase
    end
  end

  // Datapath: operand capture, chunk shifting, flag latching and result registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      type_r       <= '0;
      op_a         <= '0;
      op_b         <= '0;
      pc_r         <= '0;
      off_r        <= '0;
      addr_acc     <= '0;
      eq_acc       <= 1'b0;
      cout         <= 1'b0;
      dsign        <= 1'b0;
      s1           <= 1'b0;
      s2           <= 1'b0;
      branch_taken <= 1'b0;
      branch_addr  <= '0;
    end else if (!flush) begin
      case (state)
        IDLE: begin
          if (accept) begin
            type_r   <= branch_type;
            op_a     <= rs1_data;
            op_b     <= rs2_data;
            pc_r     <= pc;
            off_r    <= {{(WORD_SIZE-13){imm_sb[12]}}, imm_sb};
            addr_acc <= '0;
            eq_acc   <= 1'b1;
          end
        end
        CMP: begin
          op_a   <= op_a >> CHUNK;
          op_b   <= op_b >> CHUNK;
          eq_acc <= eq_acc & (op_a[CHUNK-1:0] == op_b[CHUNK-1:0]);
          if (last) begin
            cout  <= sum[CHUNK];
            dsign <= sum[CHUNK-1];
            s1    <= op_a[CHUNK-1];
            s2    <= op_b[CHUNK-1];
          end
        end
        ADDR: begin
          pc_r     <= pc_r >> CHUNK;
          off_r    <= off_r >> CHUNK;
          addr_acc <= addr_next;
          if (last) begin
            branch_addr  <= addr_next;
            branch_taken <= taken_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_res_seq.sv
// Randomized and directed checks of branch_res_seq against an arithmetic model.
module tb_branch_res_seq;

  localparam int W = 32;
  localparam int LAT = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    branch_type;
  logic [W-1:0]  rs1_data;
  logic [W-1:0]  rs2_data;
  logic [W-1:0]  pc;
  logic [12:0]   imm_sb;
  logic          flush;
  logic          resp_valid;
  logic          resp_ready;
  logic          branch_taken;
  logic [W-1:0]  branch_addr;
  logic          busy;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  branch_res_seq #(.WORD_SIZE(W), .CHUNK(8)) dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready),
    .branch_type(branch_type), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .pc(pc), .imm_sb(imm_sb), .flush(flush), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .busy(busy)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic model_taken(input logic [2:0] t, input logic [W-1:0] a, input logic [W-1:0] b);
    case (t)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) <  $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a <  b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [W-1:0] model_addr(input logic [W-1:0] p, input logic [12:0] imm);
    int signed off;
    off = $signed({{19{imm[12]}}, imm});
    return p + W'(off);
  endfunction

  // Present a request at a quiet point and hold it through the accepting edge.
  task automatic send_req(input logic [2:0] t, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] p, input logic [12:0] imm);
    branch_type = t; rs1_data = a; rs2_data = b; pc = p; imm_sb = imm;
    req_valid = 1'b1;
    #1;
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    rs1_data = $urandom; rs2_data = $urandom; pc = $urandom;
    imm_sb = 13'($urandom); branch_type = 3'($urandom);
  endtask

  // Count edges until resp_valid appears, bounded.
  task automatic wait_resp(output int edges);
    edges = 0;
    while (edges < 40) begin
      @(posedge CLK);
      edges++;
      #1;
      if (resp_valid) break;
    end
    chk("resp_timeout", {31'd0, resp_valid}, 32'd1);
  endtask

  task automatic ack();
    resp_ready = 1'b1;
    @(posedge CLK);
    #1;
    resp_ready = 1'b0;
    chk("resp_drop", {31'd0, resp_valid}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic run(input string tag, input logic [2:0] t, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] p, input logic [12:0] imm);
    int e;
    logic exp_t;
    logic [W-1:0] exp_a;
    exp_t = model_taken(t, a, b);
    exp_a = model_addr(p, imm);
    send_req(t, a, b, p, imm);
    wait_resp(e);
    chk({tag, "_lat"}, W'(e), W'(LAT));
    chk({tag, "_taken"}, {31'd0, branch_taken}, {31'd0, exp_t});
    chk({tag, "_addr"}, branch_addr, exp_a);
    ack();
  endtask

  initial begin
    int e;
    int seen;
    logic hold_t;
    logic [W-1:0] hold_a;
    logic [W-1:0] a;
    logic [W-1:0] b;

    RST = 1'b1; req_valid = 1'b0; flush = 1'b0; resp_ready = 1'b0;
    branch_type = '0; rs1_data = '0; rs2_data = '0; pc = '0; imm_sb = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_taken", {31'd0, branch_taken}, 32'd0);
    chk("rst_addr", branch_addr, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    RST = 1'b0;
    @(posedge CLK);
    #1;

    run("beq",  3'b000, 32'h1234_5678, 32'h1234_5678, 32'h0000_1000, 13'h010);
    run("bne",  3'b001, 32'h1234_5678, 32'h1234_5678, 32'h0000_1000, 13'h010);
    run("blt_m1",  3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_2000, 13'h020);
    run("bge_m1",  3'b101, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_2000, 13'h020);
    run("bltu_m1", 3'b110, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_2000, 13'h020);
    run("bgeu_m1", 3'b111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_2000, 13'h020);
    run("carry", 3'b000, 32'h1, 32'h2, 32'h0000_00FC, 13'h004);
    run("wrap",  3'b000, 32'h1, 32'h1, 32'h0000_0004, 13'h1FF8);
    run("bltu_z", 3'b110, 32'h5, 32'h0, 32'h100, 13'h0);
    run("bgeu_z", 3'b111, 32'h5, 32'h0, 32'h100, 13'h0);
    run("blt_min",  3'b100, 32'h8000_0000, 32'h7FFF_FFFF, 32'h300, 13'h008);
    run("bltu_min", 3'b110, 32'h8000_0000, 32'h7FFF_FFFF, 32'h300, 13'h008);
    run("bad_type", 3'b010, 32'h7, 32'h7, 32'h400, 13'h0FFE);
    // Hard-coded expectations for the directed address cases.
    chk("wrap_const", model_addr(32'h4, 13'h1FF8), 32'hFFFF_FFFC);

    // Flush during the second compare cycle.
    send_req(3'b000, 32'hA, 32'hA, 32'h500, 13'h010);
    @(posedge CLK);
    #1;
    flush = 1'b1;
    #1;
    chk("flush_req_ready", {31'd0, req_ready}, 32'd0);
    @(posedge CLK);
    #1;
    flush = 1'b0;
    #1;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_req_ready_after", {31'd0, req_ready}, 32'd1);
    seen = 0;
    repeat (12) begin
      @(posedge CLK);
      #1;
      if (resp_valid) seen = 1;
    end
    chk("flush_no_resp", W'(seen), 32'd0);
    run("post_flush", 3'b000, 32'hCAFE_0001, 32'hCAFE_0001, 32'h0000_1000, 13'h010);

    // Backpressure: outputs held for 5 cycles in DONE.
    send_req(3'b100, 32'hFFFF_FF00, 32'h10, 32'h0000_8000, 13'h1F00);
    wait_resp(e);
    hold_t = branch_taken;
    hold_a = branch_addr;
    chk("bp_taken", {31'd0, hold_t}, 32'd1);
    chk("bp_addr", hold_a, 32'h0000_7F00);
    repeat (5) begin
      @(posedge CLK);
      #1;
      chk("bp_valid", {31'd0, resp_valid}, 32'd1);
      chk("bp_taken_hold", {31'd0, branch_taken}, {31'd0, hold_t});
      chk("bp_addr_hold", branch_addr, hold_a);
    end
    ack();

    // Reset in the middle of the address phase.
    send_req(3'b001, 32'h1, 32'h2, 32'h0000_0100, 13'h004);
    repeat (5) @(posedge CLK);
    #1;
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    chk("mid_rst_valid", {31'd0, resp_valid}, 32'd0);
    chk("mid_rst_taken", {31'd0, branch_taken}, 32'd0);
    chk("mid_rst_addr", branch_addr, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd0);
    RST = 1'b0;
    @(posedge CLK);
    #1;

    // Random traffic.
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
      if ($urandom_range(0, 4) == 0) b = {a[31:8], b[7:0]};
      run("rand", 3'($urandom_range(0, 7)), a, b, W'($urandom), {12'($urandom), 1'b0});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
